countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the counter and load-value width in bits.
REQ-002 SHALL have port aclk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port arstn, input, 1, reset: synchronous and active-low.
REQ-004 SHALL have port clr, input, 1, abort: cancels the countdown and returns to idle.
REQ-005 SHALL have port load_valid, input, 1, load request.
REQ-006 SHALL have port load_ready, output, 1, load accepted when high together with load_valid.
REQ-007 SHALL have port load_value, input, WIDTH, start value of the countdown.
REQ-008 SHALL have port reload, input, 1, auto-reload mode flag, sampled with the load.
REQ-009 SHALL have port dec, input, 1, decrement strobe.
REQ-010 SHALL have port out, output, WIDTH, current count.
REQ-011 SHALL have port busy, output, 1, high in RUN and EXPIRED.
REQ-012 SHALL have port expired, output, 1, one-cycle pulse when the count reaches zero.
REQ-013 SHALL have port expire_cnt, output, WIDTH, number of expirations since the last load; saturates at all-ones.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and EXPIRED; load_ready SHALL be high only in IDLE.
REQ-015 In IDLE, on load_valid&&load_ready, the block SHALL perform all of the following in one edge: out<=load_value, period_r<=load_value, reload_r<=reload, expire_cnt<=0.
REQ-016 After an IDLE load, next state SHALL be EXPIRED if load_value==0, else RUN.
REQ-017 In RUN, dec=1 SHALL give out<=out-1; if out==1, next state SHALL be EXPIRED with out=0.
REQ-018 In RUN, dec=0 SHALL hold out.
REQ-019 In RUN and EXPIRED, load_valid SHALL be ignored: no state change, no capture.
REQ-020 EXPIRED SHALL last exactly one cycle, with expired=1 and expire_cnt incremented (saturating at all-ones); dec SHALL be ignored in this cycle.
REQ-021 Leaving EXPIRED with reload_r=1 and period_r!=0: out<=period_r, next state RUN.
REQ-022 Leaving EXPIRED with reload_r=0 or period_r==0: out held at 0, next state IDLE.
REQ-023 Latency: expired SHALL assert on the cycle after the edge that sampled the final dec; the first reload dec SHALL be accepted on the cycle after expired.
REQ-024 clr=1 SHALL override load and dec: out<=0, next state IDLE, no expired pulse, expire_cnt kept.
REQ-025 Arithmetic SHALL be unsigned WIDTH-bit; out SHALL never wrap below 0.

Reset
REQ-026 On the aclk edge with arstn=0: state<=IDLE, out<=0, expire_cnt<=0, reload_r<=0, period_r<=0.
REQ-027 During reset: expired=0, busy=0, load_ready=1.
REQ-028 Reset SHALL take priority over clr, load and dec, including mid-countdown.
REQ-029 No asynchronous reset path SHALL exist.

Structure
REQ-030 The FSM state encoding (IDLE=0, RUN=1, EXPIRED=2, 2 bits) and the default WIDTH constant SHALL live in shared package counter_pkg.
REQ-031 The expiration counter SHALL be a sub-module sat_counter: WIDTH parameter; clear and inc inputs; saturating output. It is reusable by other counter blocks.
REQ-032 All outputs except load_ready and busy SHALL be registered; load_ready and busy SHALL be decoded from the state register only.

Verification
REQ-033 Basic countdown: load 3 with reload=0, then dec high continuously -> out 3,2,1,0; expired one cycle; then IDLE with load_ready=1 and expire_cnt=1.
REQ-034 Auto-reload: load 2 with reload=1, dec high for 8 cycles -> expired pulses every 3 cycles; out returns to 2 after each pulse; expire_cnt=2 after 8 cycles.
REQ-035 Zero load: load 0 with reload=1 -> EXPIRED next cycle, then IDLE; out stays 0; expire_cnt=1.
REQ-036 Abort and ignored load: load 5, 2 decs, clr -> out=0, IDLE, no expired pulse; load_valid held during RUN -> not accepted, out unchanged.
REQ-037 Reset mid-count: load 200, 10 decs, then arstn=0 for one edge -> out=0, expire_cnt=0, IDLE on the next cycle; arstn toggled between edges only -> no effect.
REQ-038 Saturation (WIDTH=2): load 1 with reload=1, dec held -> expire_cnt stops at 3.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter family: FSM state encoding and default width.
package counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: clear wins over inc, and the count sticks at all-ones.
module sat_counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Loadable countdown timer with optional auto-reload, one-cycle expiry pulse
// and a saturating count of expirations since the last load.
module countdown_timer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             reload,
    input  logic             dec,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             expired,
    output logic [WIDTH-1:0] expire_cnt
);

    state_t           state;
    logic [WIDTH-1:0] period_r;
    logic             reload_r;
    logic             load_fire;
    logic             cnt_clear;
    logic             cnt_inc;

    assign load_ready = (state == IDLE);
    assign busy       = (state == RUN) || (state == EXPIRED);

    assign load_fire = load_ready && load_valid && !clr;
    // The count of expirations advances as EXPIRED is left, so an abort in that cycle leaves it untouched.
    assign cnt_clear = !arstn || load_fire;
    assign cnt_inc   = !clr && (state == EXPIRED);

    sat_counter #(
        .WIDTH(WIDTH)
    ) u_expire_cnt (
        .clk  (aclk),
        .clear(cnt_clear),
        .inc  (cnt_inc),
        .count(expire_cnt)
    );

    always_ff @(posedge aclk) begin
        if (!arstn) begin
            state    <= IDLE;
            out      <= '0;
            period_r <= '0;
            reload_r <= 1'b0;
            expired  <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            out     <= '0;
            expired <= 1'b0;
        end else begin
            expired <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        out      <= load_value;
                        period_r <= load_value;
                        reload_r <= reload;
                        if (load_value == '0) begin
                            state   <= EXPIRED;
                            expired <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (dec && (out != '0)) begin
                        out <= out - WIDTH'(1);
                        if (out == WIDTH'(1)) begin
                            state   <= EXPIRED;
                            expired <= 1'b1;
                        end
                    end
                end
                EXPIRED: begin
                    if (reload_r && (period_r != '0)) begin
                        out   <= period_r;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    out   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer at WIDTH=8 and WIDTH=2 against a behavioural model.
module tb_countdown_timer;

    logic       aclk;
    logic       arstn;
    logic       clr;
    logic       load_valid;
    logic [7:0] load_value;
    logic [1:0] load_value2;
    logic       reload;
    logic       dec;

    logic       load_ready8, busy8, expired8;
    logic [7:0] out8, expire_cnt8;
    logic       load_ready2, busy2, expired2;
    logic [1:0] out2, expire_cnt2;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    typedef struct {
        int unsigned cnt;
        int unsigned per;
        int unsigned hits;
        bit          counting;
        bit          firing;
        bit          auto_rl;
    } model_t;

    model_t m8;
    model_t m2;

    assign load_value2 = load_value[1:0];

    countdown_timer #(.WIDTH(8)) u_dut8 (
        .aclk(aclk), .arstn(arstn), .clr(clr), .load_valid(load_valid),
        .load_ready(load_ready8), .load_value(load_value), .reload(reload), .dec(dec),
        .out(out8), .busy(busy8), .expired(expired8), .expire_cnt(expire_cnt8)
    );

    countdown_timer #(.WIDTH(2)) u_dut2 (
        .aclk(aclk), .arstn(arstn), .clr(clr), .load_valid(load_valid),
        .load_ready(load_ready2), .load_value(load_value2), .reload(reload), .dec(dec),
        .out(out2), .busy(busy2), .expired(expired2), .expire_cnt(expire_cnt2)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock edge of the timer's behaviour, described in terms of what the user sees.
    function automatic model_t model_next(input model_t s, input int unsigned maxv, input int unsigned val);
        model_t n = s;
        if (!arstn) begin
            n.cnt = 0; n.per = 0; n.hits = 0;
            n.counting = 0; n.firing = 0; n.auto_rl = 0;
        end else if (clr) begin
            n.cnt = 0; n.counting = 0; n.firing = 0;
        end else if (s.firing) begin
            n.firing = 0;
            n.hits = (s.hits < maxv) ? s.hits + 1 : maxv;
            if (s.auto_rl && s.per != 0) begin
                n.cnt = s.per; n.counting = 1;
            end else begin
                n.counting = 0;
            end
        end else if (s.counting) begin
            if (dec) begin
                n.cnt = s.cnt - 1;
                if (n.cnt == 0) begin
                    n.counting = 0; n.firing = 1;
                end
            end
        end else if (load_valid) begin
            n.cnt = val; n.per = val; n.auto_rl = reload; n.hits = 0;
            if (val == 0) n.firing = 1;
            else          n.counting = 1;
        end
        return n;
    endfunction

    task automatic check_all();
        check_eq("out8",        32'(out8),        m8.cnt);
        check_eq("busy8",       32'(busy8),       32'(m8.counting || m8.firing));
        check_eq("expired8",    32'(expired8),    32'(m8.firing));
        check_eq("load_ready8", 32'(load_ready8), 32'(!m8.counting && !m8.firing));
        check_eq("expcnt8",     32'(expire_cnt8), m8.hits);
        check_eq("out2",        32'(out2),        m2.cnt);
        check_eq("busy2",       32'(busy2),       32'(m2.counting || m2.firing));
        check_eq("expired2",    32'(expired2),    32'(m2.firing));
        check_eq("load_ready2", 32'(load_ready2), 32'(!m2.counting && !m2.firing));
        check_eq("expcnt2",     32'(expire_cnt2), m2.hits);
    endtask

    task automatic step();
        @(posedge aclk);
        m8 = model_next(m8, 255, 32'(load_value));
        m2 = model_next(m2, 3, 32'(load_value2));
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        arstn = 1'b1; clr = 1'b0; load_valid = 1'b0; load_value = '0; reload = 1'b0; dec = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] val, input logic rl);
        load_valid = 1'b1; load_value = val; reload = rl;
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        m8 = '{default: 0};
        m2 = '{default: 0};
        idle_inputs();
        arstn = 1'b0;
        step();
        check_eq("rst_load_ready", 32'(load_ready8), 32'd1);
        check_eq("rst_out", 32'(out8), 32'd0);
        arstn = 1'b1;
        step();

        // Basic countdown
        do_load(8'd3, 1'b0);
        dec = 1'b1;
        repeat (4) step();
        dec = 1'b0;
        check_eq("basic_expcnt", 32'(expire_cnt8), 32'd1);
        check_eq("basic_ready", 32'(load_ready8), 32'd1);

        // Auto-reload
        do_load(8'd2, 1'b1);
        dec = 1'b1;
        repeat (8) step();
        dec = 1'b0;
        check_eq("reload_expcnt", 32'(expire_cnt8), 32'd2);
        clr = 1'b1; step(); clr = 1'b0;

        // Zero load with reload set
        do_load(8'd0, 1'b1);
        check_eq("zero_expired", 32'(expired8), 32'd1);
        step();
        check_eq("zero_expcnt", 32'(expire_cnt8), 32'd1);
        check_eq("zero_out", 32'(out8), 32'd0);

        // Abort, and a load request ignored while running
        do_load(8'd5, 1'b0);
        dec = 1'b1; repeat (2) step(); dec = 1'b0;
        load_valid = 1'b1; load_value = 8'd77;
        repeat (3) step();
        check_eq("ignored_load", 32'(out8), 32'd3);
        load_valid = 1'b0;
        clr = 1'b1; step(); clr = 1'b0;
        check_eq("abort_out", 32'(out8), 32'd0);
        check_eq("abort_expired", 32'(expired8), 32'd0);
        step();

        // Reset glitch between edges, then a real reset mid-count
        do_load(8'd200, 1'b0);
        dec = 1'b1; repeat (10) step(); dec = 1'b0;
        #2 arstn = 1'b0; #2 arstn = 1'b1;
        step();
        check_eq("glitch_out", 32'(out8), 32'd190);
        arstn = 1'b0; dec = 1'b1; clr = 1'b1; load_valid = 1'b1;
        step();
        idle_inputs();
        check_eq("midrst_out", 32'(out8), 32'd0);
        check_eq("midrst_busy", 32'(busy8), 32'd0);
        step();

        // Saturation of the expiry count on the narrow instance
        do_load(8'd1, 1'b1);
        dec = 1'b1;
        repeat (12) step();
        dec = 1'b0;
        check_eq("sat_expcnt2", 32'(expire_cnt2), 32'd3);
        clr = 1'b1; step(); clr = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            arstn      = ($urandom_range(0, 149) != 0);
            clr        = ($urandom_range(0, 39) == 0);
            load_valid = ($urandom_range(0, 9) < 3);
            load_value = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 5));
            reload     = 1'($urandom_range(0, 1));
            dec        = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
